// File: rtl/score_cmd_scheduler.sv
// score_cmd_scheduler: queues score requests and drives a BCD counter mode/strobe.
// Define SCORE_SCHED_UNDO_EN to build the undo-last-increment path.
module score_cmd_scheduler #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_code,
  input  logic              undo_req,
  output logic [2:0]        switch_out,
  output logic              btn_out,
  output logic              busy,
  output logic              fifo_full,
  output logic [9:0]        score_total,
  output logic              drop_pulse
);

  localparam int IW   = $clog2(NREQ);
  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int TW   = $clog2(TMAX + 1);
`ifdef SCORE_SCHED_UNDO_EN
  localparam int EW = 3;
`else
  localparam int EW = 2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tcnt, tcnt_nxt;

  logic [NREQ-1:0] req_q;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] edge_v;
  logic [NREQ-1:0] grant;
  logic [1:0]      code_l [NREQ];
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan;
  logic            grant_vld;
  logic            can_grant;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop, empty;
  logic [EW-1:0]   push_data, head;

  logic [1:0]      cur_code;
  logic [2:0]      mode;
  logic [10:0]     sum;
  logic            is_dec, fits, again;
  logic            chk_ok, chk_drop, edge_drop;
  logic            undo_push, undo_drop;

`ifdef SCORE_SCHED_UNDO_EN
  logic       undo_q;
  logic       undo_edge;
  logic       hist_vld;
  logic [1:0] hist_code;
  logic       cur_undo;
  logic [1:0] undo_rem;
  logic [7:0] drop_cnt;

  assign undo_edge = undo_req & ~undo_q;
  assign undo_push = undo_edge & hist_vld & ~fifo_full;
  assign undo_drop = undo_edge & ~undo_push;
  assign push_data = undo_push ? {1'b1, hist_code}
                               : {1'b0, code_l[grant_idx]};
  assign is_dec    = cur_undo | (cur_code == 2'b00);
  assign again     = cur_undo & (undo_rem > 2'd1);
`else
  logic unused_undo;

  assign unused_undo = undo_req;
  assign undo_push   = 1'b0;
  assign undo_drop   = 1'b0;
  assign push_data   = code_l[grant_idx];
  assign is_dec      = (cur_code == 2'b00);
  assign again       = 1'b0;
`endif

  assign edge_v    = req & ~req_q;
  assign empty     = (count == '0);
  assign fifo_full = (count == (AW+1)'(DEPTH));
  assign can_grant = ~fifo_full & ~undo_push;
  assign push      = grant_vld | undo_push;
  assign head      = mem[rd_ptr];
  assign edge_drop = |(edge_v & pending & ~grant);

  // Round-robin scan starting at the slot after the last grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    scan      = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = IW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_vld && can_grant && pending[scan]) begin
        grant_vld = 1'b1;
        grant_idx = scan;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      pending <= '0;
      rr_ptr  <= '0;
      for (int i = 0; i < NREQ; i++) code_l[i] <= '0;
    end else begin
      req_q <= req;
      if (grant_vld)
        rr_ptr <= (int'(grant_idx) == NREQ - 1) ? '0
                                                : grant_idx + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (edge_v[i]) begin
          pending[i] <= 1'b1;
          if (!pending[i] || grant[i])
            code_l[i] <= req_code[2*i +: 2];
        end else if (grant[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign sum  = {1'b0, score_total} + {9'd0, cur_code};
  assign fits = is_dec ? (score_total != 10'd0) : (sum <= 11'd999);

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    pop       = 1'b0;
    chk_ok    = 1'b0;
    chk_drop  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (fits) begin
          chk_ok    = 1'b1;
          state_nxt = S_SETUP;
          tcnt_nxt  = TW'(SETUP_CYC - 1);
        end else begin
          chk_drop  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (tcnt == '0) begin
          state_nxt = S_HIGH;
          tcnt_nxt  = TW'(PULSE_CYC - 1);
        end else begin
          tcnt_nxt = tcnt - 1'b1;
        end
      end
      S_HIGH: begin
        if (tcnt == '0) begin
          state_nxt = S_LOW;
          tcnt_nxt  = TW'(PULSE_CYC - 1);
        end else begin
          tcnt_nxt = tcnt - 1'b1;
        end
      end
      S_LOW: begin
        if (tcnt == '0) state_nxt = again ? S_CHECK : S_IDLE;
        else            tcnt_nxt  = tcnt - 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mode = 3'b111;
    if (!is_dec) begin
      unique case (cur_code)
        2'b01:   mode = 3'b001;
        2'b10:   mode = 3'b010;
        default: mode = 3'b100;
      endcase
    end
  end

  // Select is only driven while a command owns the counter.
  assign switch_out = (state == S_SETUP || state == S_HIGH ||
                       state == S_LOW) ? mode : 3'b000;
  assign btn_out    = (state == S_HIGH);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      cur_code    <= '0;
      score_total <= '0;
      drop_pulse  <= 1'b0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      if (pop) cur_code <= head[1:0];
      if (chk_ok)
        score_total <= is_dec ? score_total - 10'd1 : sum[9:0];
      drop_pulse <= edge_drop | chk_drop | undo_drop;
    end
  end

`ifdef SCORE_SCHED_UNDO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      undo_q    <= 1'b0;
      hist_vld  <= 1'b0;
      hist_code <= '0;
      cur_undo  <= 1'b0;
      undo_rem  <= '0;
      drop_cnt  <= '0;
    end else begin
      undo_q <= undo_req;
      if (pop) begin
        cur_undo <= head[2];
        undo_rem <= head[1:0];
      end else if (state == S_LOW && state_nxt == S_CHECK) begin
        undo_rem <= undo_rem - 2'd1;
      end
      if (undo_push) hist_vld <= 1'b0;
      if (chk_ok && !is_dec) begin
        hist_vld  <= 1'b1;
        hist_code <= cur_code;
      end else if (chk_ok && !cur_undo) begin
        hist_vld <= 1'b0;
      end
      drop_cnt <= drop_cnt
                + 8'($countones(edge_v & pending & ~grant))
                + 8'(chk_drop) + 8'(undo_drop);
    end
  end
`endif

endmodule
